serial_recv_align: RTL and testbench

Receive-side counterpart of the 16-bit LVDS DDR serial link. Accepts the 2-bit-per-clock stream delivered by the input DDR register (IDDR2 + IBUFDS, outside this block) in the fast serial clock domain. Finds the 16-bit word boundary from a training pattern, then emits one parallel 16-bit word every 8 clocks with a valid strobe. MSB-first bit order on the wire; DIN[1] is the earlier bit of each pair.

---
 rtl/serial_recv_align.sv | 135 +++++++++++++
 tb/tb_serial_recv_align.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_recv_align.sv
// serial_recv_align: word aligner for a 2-bit-per-clock DDR serial link.
// It hunts for the 16-bit word boundary using a training pattern. Once
// locked, it emits one recovered word every 8 serial clocks.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_HUNT   | trying the current bit offset; slip by one bit on mismatch
// S_CONFIRM| pattern seen at this offset; counting consecutive matches
// S_LOCKED | boundary fixed; DOUT updated every frame, errors counted
module serial_recv_align #(
  parameter logic [15:0] PATTERN    = 16'h00FF,
  parameter int          LOCK_COUNT = 4
) (
  input  logic        CLKS,
  input  logic        RSTXS,
  input  logic [1:0]  DIN,
  input  logic        TRAIN,
  input  logic        ALIGN_REQ,
  output logic [15:0] DOUT,
  output logic        DOUT_VLD,
  output logic        LOCKED,
  output logic [7:0]  ERR_CNT
);

  localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_CONFIRM = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] hist_q;
  logic [2:0]  ph_q;
  logic [3:0]  ofs_q, ofs_d;
  logic [3:0]  mcnt_q, mcnt_d;
  logic [15:0] dout_q, dout_d;
  logic        vld_q, vld_d;
  logic [7:0]  err_q, err_d;
  logic [15:0] cand_w;
  logic        eval;
  logic        match;

  // Candidate word at the current bit offset; odd offsets cover half-pair slips.
  assign cand_w = hist_q[{1'b0, ofs_q} +: 16];
  assign eval   = (ph_q == 3'd7);
  assign match  = (cand_w == PATTERN);

  // Shift history and free-running frame phase; phase is never touched by alignment.
  always_ff @(posedge CLKS or negedge RSTXS) begin
    if (!RSTXS) begin
      hist_q <= 32'h0;
      ph_q   <= 3'd0;
    end else begin
      hist_q <= {hist_q[29:0], DIN[1], DIN[0]};
      ph_q   <= ph_q + 3'd1;
    end
  end

  // State, offset, match count and registered outputs.
  always_ff @(posedge CLKS or negedge RSTXS) begin
    if (!RSTXS) begin
      state_q <= S_HUNT;
      ofs_q   <= 4'd0;
      mcnt_q  <= 4'd0;
      dout_q  <= 16'h0000;
      vld_q   <= 1'b0;
      err_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ofs_q   <= ofs_d;
      mcnt_q  <= mcnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; ALIGN_REQ overrides any frame evaluation in the same cycle.
  always_comb begin
    state_d = state_q;
    ofs_d   = ofs_q;
    mcnt_d  = mcnt_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    err_d   = err_q;
    if (ALIGN_REQ) begin
      // Offset is kept so an undisturbed link relocks without slipping.
      state_d = S_HUNT;
      mcnt_d  = 4'd0;
      err_d   = 8'h00;
    end else if (eval) begin
      case (state_q)
        S_HUNT: begin
          if (match) begin
            mcnt_d  = 4'd1;
            state_d = S_CONFIRM;
          end else begin
            ofs_d = ofs_q + 4'd1;
          end
        end
        S_CONFIRM: begin
          if (match) begin
            mcnt_d = mcnt_q + 4'd1;
            if (mcnt_q + 4'd1 == LOCK_CNT4) begin
              state_d = S_LOCKED;
            end
          end else begin
            ofs_d   = ofs_q + 4'd1;
            mcnt_d  = 4'd0;
            state_d = S_HUNT;
          end
        end
        S_LOCKED: begin
          dout_d = cand_w;
          vld_d  = 1'b1;
          if (TRAIN && !match && (err_q != 8'hFF)) begin
            err_d = err_q + 8'h01;
          end
        end
        default: begin
          state_d = S_HUNT;
          mcnt_d  = 4'd0;
        end
      endcase
    end
  end

  assign DOUT     = dout_q;
  assign DOUT_VLD = vld_q;
  assign LOCKED   = (state_q == S_LOCKED);
  assign ERR_CNT  = err_q;

endmodule

// File: tb/tb_serial_recv_align.sv
// Bench for serial_recv_align: directed steps plus a randomized stream.
// Expected values come from a bit-level reference model.
module tb_serial_recv_align;

  localparam logic [15:0] PAT = 16'h00FF;
  localparam logic [15:0] BAD = 16'h01FF;
  localparam int          LC  = 4;

  logic        CLKS = 1'b0;
  logic        RSTXS = 1'b0;
  logic [1:0]  DIN = 2'b00;
  logic        TRAIN = 1'b0;
  logic        ALIGN_REQ = 1'b0;
  logic [15:0] DOUT;
  logic        DOUT_VLD;
  logic        LOCKED;
  logic [7:0]  ERR_CNT;

  int total = 0;
  int bad = 0;

  bit txq[$];
  bit rxq[$];
  bit fill_rand = 1'b0;
  bit areq_next = 1'b0;

  int          m_cyc;
  bit          m_locked;
  int          m_match;
  int          m_ofs;
  int          m_err;
  logic [15:0] m_dout;
  bit          m_vld;

  serial_recv_align #(.PATTERN(PAT), .LOCK_COUNT(LC)) dut (
    .CLKS(CLKS), .RSTXS(RSTXS), .DIN(DIN), .TRAIN(TRAIN), .ALIGN_REQ(ALIGN_REQ),
    .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .LOCKED(LOCKED), .ERR_CNT(ERR_CNT)
  );

  always #5 CLKS = ~CLKS;

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) txq.push_back(w[i]);
  endfunction

  function automatic void drop_bits(input int n);
    for (int i = 0; i < n; i++) if (txq.size() > 0) void'(txq.pop_front());
  endfunction

  // The word whose last bit lies ofs bits before the newest received bit.
  function automatic logic [15:0] model_word(input int ofs);
    logic [15:0] w;
    int n;
    n = rxq.size();
    for (int i = 0; i < 16; i++) w[15-i] = rxq[n-16-ofs+i];
    return w;
  endfunction

  function automatic void model_reset();
    m_cyc = 0; m_locked = 0; m_match = 0; m_ofs = 0; m_err = 0;
    m_dout = 16'h0; m_vld = 0;
    rxq.delete();
    for (int i = 0; i < 32; i++) rxq.push_back(1'b0);
  endfunction

  function automatic void model_step(input logic [1:0] d, input logic t, input logic a);
    logic [15:0] w;
    bit ev;
    w = model_word(m_ofs);
    ev = ((m_cyc % 8) == 7);
    m_vld = 0;
    if (a) begin
      m_locked = 0; m_match = 0; m_err = 0;
    end else if (ev) begin
      if (m_locked) begin
        m_dout = w;
        m_vld = 1;
        if (t && (w != PAT) && (m_err < 255)) m_err = m_err + 1;
      end else if (w == PAT) begin
        m_match = m_match + 1;
        if (m_match == LC) m_locked = 1;
      end else begin
        m_ofs = (m_ofs + 1) % 16;
        m_match = 0;
      end
    end
    rxq.push_back(d[1]);
    rxq.push_back(d[0]);
    while (rxq.size() > 64) void'(rxq.pop_front());
    m_cyc++;
  endfunction

  task automatic cycle();
    logic [1:0] d;
    logic [15:0] w;
    if (txq.size() < 2) begin
      w = PAT;
      if (fill_rand && ($urandom_range(0, 99) < 15)) w = 16'($urandom);
      push_word(w);
    end
    d[1] = txq.pop_front();
    d[0] = txq.pop_front();
    DIN = d;
    ALIGN_REQ = areq_next;
    areq_next = 1'b0;
    @(posedge CLKS);
    model_step(DIN, TRAIN, ALIGN_REQ);
    #1;
    check("dout", 32'(DOUT), 32'(m_dout));
    check("dout_vld", 32'(DOUT_VLD), 32'(m_vld));
    check("locked", 32'(LOCKED), 32'(m_locked));
    check("err_cnt", 32'(ERR_CNT), 32'(m_err));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    RSTXS = 1'b0;
    DIN = 2'b00;
    ALIGN_REQ = 1'b0;
    areq_next = 1'b0;
    txq.delete();
    model_reset();
    repeat (2) @(posedge CLKS);
    #1;
    RSTXS = 1'b1;
  endtask

  initial begin
    bit found;
    logic [15:0] w;

    // Lock on an aligned pattern stream at offset 0.
    do_reset();
    check("rst_dout", 32'(DOUT), 32'h0);
    check("rst_vld", 32'(DOUT_VLD), 32'h0);
    check("rst_locked", 32'(LOCKED), 32'h0);
    check("rst_err", 32'(ERR_CNT), 32'h0);
    TRAIN = 1'b1;
    fill_rand = 1'b0;
    push_word(PAT);
    drop_bits(2);
    run(31);
    check("t1_locked_edge31", 32'(LOCKED), 32'h0);
    run(1);
    check("t1_locked_edge32", 32'(LOCKED), 32'h1);
    check("t1_ofs", 32'(dut.ofs_q), 32'h0);
    check("t1_err", 32'(ERR_CNT), 32'h0);
    run(16);

    // Stream advanced by 5 bits: five slips, then four matches, then payload.
    do_reset();
    TRAIN = 1'b1;
    push_word(PAT);
    drop_bits(7);
    run(71);
    check("t2_locked_edge71", 32'(LOCKED), 32'h0);
    run(1);
    check("t2_locked_edge72", 32'(LOCKED), 32'h1);
    check("t2_ofs", 32'(dut.ofs_q), 32'h5);
    TRAIN = 1'b0;
    push_word(16'hA5C3);
    push_word(16'h1234);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      cycle();
      if (DOUT_VLD && DOUT == 16'hA5C3) found = 1'b1;
    end
    check("t2_a5c3_seen", 32'(found), 32'h1);
    run(7);
    check("t2_vld_gap", 32'(DOUT_VLD), 32'h0);
    run(1);
    check("t2_1234_vld", 32'(DOUT_VLD), 32'h1);
    check("t2_1234_val", 32'(DOUT), 32'h1234);

    // Corrupted training words while locked, then saturation.
    TRAIN = 1'b1;
    push_word(PAT); push_word(BAD); push_word(PAT); push_word(PAT); push_word(BAD);
    push_word(PAT); push_word(BAD); push_word(PAT); push_word(PAT);
    run(8 * 12);
    check("t3_err3", 32'(ERR_CNT), 32'h3);
    check("t3_still_locked", 32'(LOCKED), 32'h1);
    for (int i = 0; i < 300; i++) begin
      w = 16'($urandom);
      if (w == PAT) w = BAD;
      push_word(w);
    end
    run(8 * 303);
    check("t3_err_sat", 32'(ERR_CNT), 32'hFF);
    check("t3_locked_sat", 32'(LOCKED), 32'h1);

    // ALIGN_REQ on an evaluation cycle while locked.
    for (int i = 0; i < 8 && (m_cyc % 8) != 7; i++) cycle();
    areq_next = 1'b1;
    cycle();
    check("t5_no_vld", 32'(DOUT_VLD), 32'h0);
    check("t5_unlocked", 32'(LOCKED), 32'h0);
    check("t5_err_clr", 32'(ERR_CNT), 32'h0);
    run(31);
    check("t5_relock_31", 32'(LOCKED), 32'h0);
    run(1);
    check("t5_relock_32", 32'(LOCKED), 32'h1);
    check("t5_ofs_kept", 32'(dut.ofs_q), 32'h5);

    // Asynchronous reset mid-frame while locked.
    push_word(BAD);
    run(24);
    check("t6_err_pre", 32'(ERR_CNT), 32'h1);
    #2;
    RSTXS = 1'b0;
    #1;
    check("t6_dout", 32'(DOUT), 32'h0);
    check("t6_locked", 32'(LOCKED), 32'h0);
    check("t6_err", 32'(ERR_CNT), 32'h0);
    check("t6_ofs", 32'(dut.ofs_q), 32'h0);

    // Rehunt from scratch: CONFIRM interrupted after two matches.
    do_reset();
    push_word(PAT);
    drop_bits(2);
    push_word(PAT);
    push_word(BAD);
    run(16);
    check("t4_mcnt2", 32'(dut.mcnt_q), 32'h2);
    check("t4_not_locked", 32'(LOCKED), 32'h0);
    run(8);
    check("t4_ofs1", 32'(dut.ofs_q), 32'h1);
    check("t4_mcnt0", 32'(dut.mcnt_q), 32'h0);
    check("t4_locked0", 32'(LOCKED), 32'h0);
    run(151);
    check("t4_wrap_175", 32'(LOCKED), 32'h0);
    run(1);
    check("t4_wrap_176", 32'(LOCKED), 32'h1);
    check("t4_wrap_ofs", 32'(dut.ofs_q), 32'h0);

    // Randomized stream: random offset, corrupted words, TRAIN and ALIGN_REQ.
    do_reset();
    fill_rand = 1'b1;
    push_word(PAT);
    drop_bits($urandom_range(0, 31));
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) TRAIN = ~TRAIN;
      if ($urandom_range(0, 149) == 0) areq_next = 1'b1;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
